// File: rtl/bcd_display_scheduler_if.sv
// Convert/display bundle shared by the BCD scheduler and whatever drives it.
// The master side issues start/binary; the slave side returns status, digits and scan lines.
interface bcd_display_scheduler_if;
    logic        start;
    logic [11:0] binary;
    logic        busy;
    logic        done;
    logic [3:0]  thos;
    logic [3:0]  huns;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output start, binary,
        input  busy, done, thos, huns, tens, ones, an, seg
    );

    modport slave (
        input  start, binary,
        output busy, done, thos, huns, tens, ones, an, seg
    );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Double-dabble binary-to-BCD converter feeding a 4-digit multiplexed 7-seg scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_scheduler #(
    parameter int REFRESH_DIV = 50000,
    parameter int BIN_W       = 12
) (
    input logic                    clk,
    input logic                    rst_n,
    bcd_display_scheduler_if.slave bus
);

    localparam int WW = BIN_W + 16;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_work;
    logic [3:0]      r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_thos;
    logic [3:0]      r_huns;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;

    logic [CW-1:0]   r_scan;
    logic [1:0]      r_idx;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic [WW-1:0]   w_adj;
    logic [WW-1:0]   w_shl;
    logic            w_tc;
    logic [1:0]      w_idx_nx;
    logic [3:0]      w_dig;
    logic            w_blank;
    logic [6:0]      w_seg;

    // Add-3 correction on each BCD nibble before the shift
    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < 4; k++) begin
            if (r_work[BIN_W+4*k +: 4] >= 4'd5)
                w_adj[BIN_W+4*k +: 4] = r_work[BIN_W+4*k +: 4] + 4'd3;
        end
        w_shl = {w_adj[WW-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_thos  <= '0;
            r_huns  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_work  <= {16'b0, bus.binary};
                        r_cnt   <= 4'd12;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_shl;
                    r_cnt  <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_thos  <= w_shl[BIN_W+12 +: 4];
                        r_huns  <= w_shl[BIN_W+8 +: 4];
                        r_tens  <= w_shl[BIN_W+4 +: 4];
                        r_ones  <= w_shl[BIN_W +: 4];
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_tc     = (r_scan == CW'(REFRESH_DIV - 1));
    assign w_idx_nx = w_tc ? r_idx + 2'd1 : r_idx;

    always_comb begin
        w_dig = r_ones;
        unique case (w_idx_nx)
            2'd0: w_dig = r_ones;
            2'd1: w_dig = r_tens;
            2'd2: w_dig = r_huns;
            2'd3: w_dig = r_thos;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        unique case (w_idx_nx)
            2'd3: w_blank = (r_thos == 4'd0);
            2'd2: w_blank = (r_thos == 4'd0) && (r_huns == 4'd0);
            2'd1: w_blank = (r_thos == 4'd0) && (r_huns == 4'd0)
                         && (r_tens == 4'd0);
            2'd0: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg = 7'b1111111;
        if (!w_blank) begin
            case (w_dig)
                4'd0: w_seg = 7'b1000000;
                4'd1: w_seg = 7'b1111001;
                4'd2: w_seg = 7'b0100100;
                4'd3: w_seg = 7'b0110000;
                4'd4: w_seg = 7'b0011001;
                4'd5: w_seg = 7'b0010010;
                4'd6: w_seg = 7'b0000010;
                4'd7: w_seg = 7'b1111000;
                4'd8: w_seg = 7'b0000000;
                4'd9: w_seg = 7'b0010000;
                default: w_seg = 7'b1111111;
            endcase
        end
    end

    // an and seg are both derived from the next index so they switch together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_an   <= 4'b1110;
            r_seg  <= 7'b1000000;
        end else begin
            r_scan <= w_tc ? '0 : r_scan + 1'b1;
            r_idx  <= w_idx_nx;
            r_an   <= ~(4'b0001 << w_idx_nx);
            r_seg  <= w_seg;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.thos = r_thos;
    assign bus.huns = r_huns;
    assign bus.tens = r_tens;
    assign bus.ones = r_ones;
    assign bus.an   = r_an;
    assign bus.seg  = r_seg;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Randomized bench for bcd_display_scheduler against a decimal-arithmetic display model.
// Runs with REFRESH_DIV=4 so the scan can be observed cycle by cycle.
module tb_bcd_display_scheduler;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   edges;
    int   ex [4];

    bcd_display_scheduler_if bus ();

    bcd_display_scheduler #(
        .REFRESH_DIV(4),
        .BIN_W(12)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: glyph = 7'b1000000;
            1: glyph = 7'b1111001;
            2: glyph = 7'b0100100;
            3: glyph = 7'b0110000;
            4: glyph = 7'b0011001;
            5: glyph = 7'b0010010;
            6: glyph = 7'b0000010;
            7: glyph = 7'b1111000;
            8: glyph = 7'b0000000;
            9: glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] seg_exp(input int idx);
        logic lead;
        lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lead = (idx > 0);
        for (int j = idx; j < 4; j++)
            if (ex[j] != 0) lead = 1'b0;
`endif
        seg_exp = lead ? 7'b1111111 : glyph(ex[idx]);
    endfunction

    task automatic set_model(input int v);
        ex[0] = v % 10;
        ex[1] = (v / 10) % 10;
        ex[2] = (v / 100) % 10;
        ex[3] = v / 1000;
    endtask

    task automatic chk_digits(input string tag);
        chk({tag, "_thos"}, 32'(bus.thos), 32'(ex[3]));
        chk({tag, "_huns"}, 32'(bus.huns), 32'(ex[2]));
        chk({tag, "_tens"}, 32'(bus.tens), 32'(ex[1]));
        chk({tag, "_ones"}, 32'(bus.ones), 32'(ex[0]));
    endtask

    task automatic convert(input logic [11:0] v);
        int dcyc;
        dcyc = -1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.binary = v;
        @(posedge clk);
        @(negedge clk);
        chk("busy_rise", 32'(bus.busy), 1);
        for (int i = 0; i <= 20; i++) begin
            if (bus.done) begin
                dcyc = i;
                break;
            end
            bus.start  = 1'($urandom_range(0, 1));
            bus.binary = 12'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_lat", 32'(dcyc), 12);
        set_model(int'(v));
        chk_digits("conv");
        chk("busy_done", 32'(bus.busy), 1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("busy_fall", 32'(bus.busy), 0);
    endtask

    task automatic scan_check(input int n);
        logic [3:0] an_e;
        logic [6:0] sg_e;
        int idx;
        repeat (n) begin
            @(negedge clk);
            idx  = (edges / 4) % 4;
            an_e = ~(4'b0001 << idx);
            sg_e = seg_exp(idx);
            chk("scan_an", 32'(bus.an), 32'(an_e));
            chk("scan_seg", 32'(bus.seg), 32'(sg_e));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int q[$];
        int ndone;
        n_tests    = 0;
        n_fail     = 0;
        bus.start  = 1'b0;
        bus.binary = '0;
        rst_n      = 1'b0;
        set_model(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk_digits("rst");
        chk("rst_an", 32'(bus.an), 32'h0000000E);
        chk("rst_seg", 32'(bus.seg), 32'h00000040);
        rst_n = 1'b1;

        convert(12'd4095);
        convert(12'd0);
        convert(12'd1000);
        convert(12'd999);
        repeat (20) convert(12'($urandom));

        convert(12'd1234);
        repeat (2) @(negedge clk);
        scan_check(32);

        convert(12'd7);
        repeat (2) @(negedge clk);
        scan_check(16);

        // start held high: one conversion per 14 cycles
        @(negedge clk);
        bus.start  = 1'b1;
        bus.binary = 12'd250;
        q = {};
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) q.push_back(i);
        end
        bus.start = 1'b0;
        chk("held_count", 32'(q.size()), 5);
        foreach (q[k]) chk("held_when", 32'(q[k]), 32'(12 + 14 * k));
        set_model(250);
        chk_digits("held");
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        chk("held_idle", 32'(bus.busy), 0);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.start  = 1'b1;
        bus.binary = 12'($urandom_range(1, 4095));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        set_model(0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_done", 32'(bus.done), 0);
        chk_digits("mid");
        chk("mid_an", 32'(bus.an), 32'h0000000E);
        chk("mid_seg", 32'(bus.seg), 32'h00000040);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mid_nodone", 32'(ndone), 0);
        chk_digits("mid_after");
        scan_check(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
